// File: rtl/condicionador_botoes.sv
// Button conditioner: 2-flop synchroniser and debounce per position, followed by an FSM
// that emits one pulse per physical press (or an error pulse when several are held).
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] botoes,
  input  logic       habilita,
  output logic       jogada_valida,
  output logic [8:0] jogada_onehot,
  output logic [3:0] jogada_idx,
  output logic       erro_multipla,
  output logic [3:0] db_estado
);

  localparam int NUM_LANES = 9;

  localparam logic [2:0] ESPERA = 3'd0;
  localparam logic [2:0] AVALIA = 3'd1;
  localparam logic [2:0] EMITE  = 3'd2;
  localparam logic [2:0] ERRO   = 3'd3;
  localparam logic [2:0] SOLTAR = 3'd4;

  logic [NUM_LANES-1:0] s1_q, s2_q;
  logic [NUM_LANES-1:0] estavel;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= botoes;
      s2_q <= s1_q;
    end
  end

  // One debounce lane per position; the counter only runs while the synced input disagrees.
  for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
    logic [CNT_W-1:0] cnt_q;
    logic             est_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q <= '0;
        est_q <= 1'b0;
      end else if (s2_q[i] == est_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        est_q <= s2_q[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign estavel[i] = est_q;
  end

  logic [2:0]           state_q, state_d;
  logic [NUM_LANES-1:0] snap_q, snap_d;
  logic [8:0]           onehot_q, onehot_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           pop;
  logic [3:0]           enc;

  always_comb begin
    pop = '0;
    enc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop = pop + {3'b0, snap_q[i]};
      if (snap_q[i]) enc = 4'(i);
    end
  end

  // Held outputs are loaded on entry to EMITE so they are valid alongside the pulse.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    case (state_q)
      ESPERA: if (|estavel) begin
        state_d = AVALIA;
        snap_d  = estavel;
      end
      AVALIA: begin
        if (pop > 4'd1) begin
          state_d = ERRO;
        end else if (pop == 4'd1 && habilita) begin
          state_d  = EMITE;
          onehot_d = snap_q;
          idx_d    = enc;
        end else begin
          state_d = SOLTAR;
        end
      end
      EMITE:   state_d = SOLTAR;
      ERRO:    state_d = SOLTAR;
      SOLTAR:  if (estavel == '0) state_d = ESPERA;
      default: state_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ESPERA;
      snap_q   <= '0;
      onehot_q <= '0;
      idx_q    <= 4'hF;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
    end
  end

  assign jogada_valida = (state_q == EMITE);
  assign erro_multipla = (state_q == ERRO);
  assign jogada_onehot = onehot_q;
  assign jogada_idx    = idx_q;
  assign db_estado     = {1'b0, state_q};

endmodule
